// File: rtl/register_file_if.sv
// Bundles the register-file access signals; the master drives the read/write request, the slave returns read data.
interface register_file_if #(
  parameter int REGISTER_WIDTH   = 64,
  parameter int REGISTERNO_WIDTH = 5
);
  logic                        in_wr_enable;
  logic                        display_regs;
  logic [REGISTERNO_WIDTH-1:0] in_rs1_regno;
  logic [REGISTERNO_WIDTH-1:0] in_rs2_regno;
  logic [REGISTERNO_WIDTH-1:0] in_rd_regno;
  logic [REGISTER_WIDTH-1:0]   in_rd_value;
  logic [REGISTER_WIDTH-1:0]   out_rs1_value;
  logic [REGISTER_WIDTH-1:0]   out_rs2_value;
  logic [REGISTER_WIDTH-1:0]   out_a0, out_a1, out_a2, out_a3;
  logic [REGISTER_WIDTH-1:0]   out_a4, out_a5, out_a6, out_a7;

  modport master (
    output in_wr_enable, display_regs, in_rs1_regno, in_rs2_regno, in_rd_regno, in_rd_value,
    input  out_rs1_value, out_rs2_value,
           out_a0, out_a1, out_a2, out_a3, out_a4, out_a5, out_a6, out_a7
  );

  modport slave (
    input  in_wr_enable, display_regs, in_rs1_regno, in_rs2_regno, in_rd_regno, in_rd_value,
    output out_rs1_value, out_rs2_value,
           out_a0, out_a1, out_a2, out_a3, out_a4, out_a5, out_a6, out_a7
  );
endinterface

// File: rtl/register_file.sv
// 32-entry, 2-read/1-write register file: zero-cycle reads with write bypass, one-cycle writes, always ready.
// x0 is hardwired to zero; defining REGFILE_DISPLAY_EN adds a simulation dump of all registers on display_regs.
module register_file #(
  parameter int REGISTER_WIDTH   = 64,
  parameter int REGISTERNO_WIDTH = 5
) (
  input  logic           clk,
  input  logic           reset,
  register_file_if.slave rf
);
  localparam int NUM_REGS = 2 ** REGISTERNO_WIDTH;

  logic [REGISTER_WIDTH-1:0] regs [NUM_REGS];
  logic                      wr_live;

  // x0 is never written, so it stays at its reset value of zero.
  assign wr_live = rf.in_wr_enable && (rf.in_rd_regno != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[rf.in_rd_regno] <= rf.in_rd_value;
    end
  end

  always_comb begin
    rf.out_rs1_value = regs[rf.in_rs1_regno];
    rf.out_rs2_value = regs[rf.in_rs2_regno];
    if (wr_live && (rf.in_rd_regno == rf.in_rs1_regno)) rf.out_rs1_value = rf.in_rd_value;
    if (wr_live && (rf.in_rd_regno == rf.in_rs2_regno)) rf.out_rs2_value = rf.in_rd_value;
  end

  // Argument registers expose stored state only, so they lag a write by one cycle.
  assign rf.out_a0 = regs[10];
  assign rf.out_a1 = regs[11];
  assign rf.out_a2 = regs[12];
  assign rf.out_a3 = regs[13];
  assign rf.out_a4 = regs[14];
  assign rf.out_a5 = regs[15];
  assign rf.out_a6 = regs[16];
  assign rf.out_a7 = regs[17];

`ifdef REGFILE_DISPLAY_EN
  function automatic string abi_name(input int i);
    if (i == 0)  return "zero";
    if (i == 1)  return "ra";
    if (i == 2)  return "sp";
    if (i == 3)  return "gp";
    if (i == 4)  return "tp";
    if (i <= 7)  return $sformatf("t%0d", i - 5);
    if (i <= 9)  return $sformatf("s%0d", i - 8);
    if (i <= 17) return $sformatf("a%0d", i - 10);
    if (i <= 27) return $sformatf("s%0d", i - 16);
    return $sformatf("t%0d", i - 25);
  endfunction

  // Nonblocking updates have not landed yet, so this shows pre-edge contents.
  always_ff @(posedge clk) begin
    if (rf.display_regs) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        $display("%-4s 0x%h", abi_name(i), regs[i]);
      end
    end
  end
`else
  logic unused_display_regs;
  assign unused_display_regs = rf.display_regs;
`endif
endmodule

// File: tb/tb_register_file.sv
// Directed table-driven check of register_file reads, writes, bypass, x0 and reset priority.
module tb_register_file;
  localparam int W = 64;

  logic clk = 1'b0;
  logic reset;
  int   nchk = 0;
  int   nerr = 0;

  register_file_if #(.REGISTER_WIDTH(W), .REGISTERNO_WIDTH(5)) bus ();

  register_file #(.REGISTER_WIDTH(W), .REGISTERNO_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (bus.slave)
  );

  always #5 clk = ~clk;

  logic [W-1:0] a [8];
  assign a[0] = bus.out_a0;
  assign a[1] = bus.out_a1;
  assign a[2] = bus.out_a2;
  assign a[3] = bus.out_a3;
  assign a[4] = bus.out_a4;
  assign a[5] = bus.out_a5;
  assign a[6] = bus.out_a6;
  assign a[7] = bus.out_a7;

  typedef struct {
    logic         rst;
    logic         wr;
    logic         disp;
    logic [4:0]   rd;
    logic [W-1:0] val;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [W-1:0] e_rs1;
    logic [W-1:0] e_rs2;
    logic [W-1:0] e_a0;
    logic [W-1:0] e_a7;
  } vec_t;

  vec_t v [15];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic wr, input logic [4:0] rd, input logic [W-1:0] val,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    reset            = r;
    bus.in_wr_enable = wr;
    bus.in_rd_regno  = rd;
    bus.in_rd_value  = val;
    bus.in_rs1_regno = rs1;
    bus.in_rs2_regno = rs2;
  endtask

  initial begin
    //        rst  wr   disp rd  val                      rs1 rs2 e_rs1                    e_rs2                    e_a0      e_a7
    v[0]  = '{1'b0,1'b0,1'b0,5'd0, 64'h0,                 5'd5, 5'd31,64'h0,                 64'h0,                 64'h0,    64'h0};
    v[1]  = '{1'b0,1'b1,1'b0,5'd10,64'h1234,              5'd10,5'd5, 64'h1234,              64'h0,                 64'h0,    64'h0};
    v[2]  = '{1'b0,1'b0,1'b0,5'd0, 64'h0,                 5'd10,5'd10,64'h1234,              64'h1234,              64'h1234, 64'h0};
    v[3]  = '{1'b0,1'b1,1'b0,5'd0, 64'hFFFF_FFFF_FFFF_FFFF,5'd0, 5'd0, 64'h0,                 64'h0,                 64'h1234, 64'h0};
    v[4]  = '{1'b0,1'b0,1'b0,5'd0, 64'h0,                 5'd0, 5'd0, 64'h0,                 64'h0,                 64'h1234, 64'h0};
    v[5]  = '{1'b0,1'b1,1'b0,5'd8, 64'h8888,              5'd8, 5'd9, 64'h8888,              64'h0,                 64'h1234, 64'h0};
    v[6]  = '{1'b0,1'b1,1'b0,5'd7, 64'hABCD,              5'd7, 5'd8, 64'hABCD,              64'h8888,              64'h1234, 64'h0};
    v[7]  = '{1'b0,1'b1,1'b0,5'd17,64'h77,                5'd7, 5'd17,64'hABCD,              64'h77,                64'h1234, 64'h0};
    v[8]  = '{1'b0,1'b1,1'b0,5'd11,64'hB1,                5'd17,5'd11,64'h77,                64'hB1,                64'h1234, 64'h77};
    v[9]  = '{1'b1,1'b1,1'b0,5'd17,64'h55,                5'd11,5'd10,64'hB1,                64'h1234,              64'h1234, 64'h77};
    v[10] = '{1'b0,1'b0,1'b0,5'd0, 64'h0,                 5'd17,5'd10,64'h0,                 64'h0,                 64'h0,    64'h0};
    v[11] = '{1'b0,1'b1,1'b0,5'd31,64'hDEAD_BEEF_CAFE_F00D,5'd31,5'd7, 64'hDEAD_BEEF_CAFE_F00D,64'h0,                 64'h0,    64'h0};
    v[12] = '{1'b0,1'b0,1'b0,5'd0, 64'h0,                 5'd31,5'd31,64'hDEAD_BEEF_CAFE_F00D,64'hDEAD_BEEF_CAFE_F00D,64'h0,    64'h0};
    v[13] = '{1'b0,1'b1,1'b0,5'd2, 64'h100,               5'd2, 5'd0, 64'h100,               64'h0,                 64'h0,    64'h0};
    v[14] = '{1'b0,1'b0,1'b1,5'd0, 64'h0,                 5'd2, 5'd31,64'h100,               64'hDEAD_BEEF_CAFE_F00D,64'h0,    64'h0};

    bus.display_regs = 1'b0;
    drive(1'b1, 1'b1, 5'd17, 64'h55, 5'd0, 5'd0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd5, 5'd31);
    #1;
    chk("reset_rs1", bus.out_rs1_value, 64'h0);
    chk("reset_rs2", bus.out_rs2_value, 64'h0);
    for (int i = 0; i < 8; i++) chk($sformatf("reset_a%0d", i), a[i], 64'h0);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(v[i].rst, v[i].wr, v[i].rd, v[i].val, v[i].rs1, v[i].rs2);
      bus.display_regs = v[i].disp;
      #1;
      chk($sformatf("v%0d_rs1", i), bus.out_rs1_value, v[i].e_rs1);
      chk($sformatf("v%0d_rs2", i), bus.out_rs2_value, v[i].e_rs2);
      chk($sformatf("v%0d_a0", i), bus.out_a0, v[i].e_a0);
      chk($sformatf("v%0d_a7", i), bus.out_a7, v[i].e_a7);
    end

    // Back-to-back writes of every argument register; out_a* must lag by one cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.display_regs = 1'b0;
      drive(1'b0, 1'b1, 5'(10 + i), 64'hA0 + 64'(i), 5'(10 + i), 5'd2);
      #1;
      chk($sformatf("b2b_bypass_%0d", i), bus.out_rs1_value, 64'hA0 + 64'(i));
      chk($sformatf("b2b_lag_a%0d", i), a[i], 64'h0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd2, 5'd17);
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("b2b_a%0d", i), a[i], 64'hA0 + 64'(i));
    chk("b2b_sp_kept", bus.out_rs1_value, 64'h100);
    chk("b2b_rs2_x17", bus.out_rs2_value, 64'hA7);

    // Reset mid-stream drops its write; the first cycle after reset writes normally.
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd12, 64'h99, 5'd12, 5'd2);
    @(negedge clk);
    drive(1'b0, 1'b1, 5'd12, 64'h42, 5'd13, 5'd2);
    #1;
    chk("rst_a2_cleared", bus.out_a2, 64'h0);
    chk("rst_sp_cleared", bus.out_rs2_value, 64'h0);
    chk("rst_x13_cleared", bus.out_rs1_value, 64'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd12, 5'd12);
    #1;
    chk("resume_a2", bus.out_a2, 64'h42);
    chk("resume_rs1", bus.out_rs1_value, 64'h42);
    chk("resume_rs2", bus.out_rs2_value, 64'h42);
    chk("resume_a7", bus.out_a7, 64'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter REGISTER_WIDTH, default 64, data width of each register.
REQ-002 SHALL have parameter REGISTERNO_WIDTH, default 5, register index width; register count = 2**REGISTERNO_WIDTH (32).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_wr_enable  input  1  write strobe for the write port.
REQ-006 SHALL have port display_regs  input  1  request to print register contents.
REQ-007 SHALL have port in_rs1_regno  input  REGISTERNO_WIDTH  read port 1 index.
REQ-008 SHALL have port in_rs2_regno  input  REGISTERNO_WIDTH  read port 2 index.
REQ-009 SHALL have port in_rd_regno  input  REGISTERNO_WIDTH  write index.
REQ-010 SHALL have port in_rd_value  input  REGISTER_WIDTH  write data.
REQ-011 SHALL have ports out_rs1_value, out_rs2_value  output  REGISTER_WIDTH  read data for ports 1 and 2.
REQ-012 SHALL have ports out_a0..out_a7  output  REGISTER_WIDTH each  contents of x10..x17 (syscall arguments).

Function
REQ-013 SHALL hold 32 registers x0..x31, each REGISTER_WIDTH bits.
REQ-014 SHALL drive out_rs1_value/out_rs2_value combinationally from the indexed register; zero-cycle read latency.
REQ-015 SHALL write in_rd_value into x[in_rd_regno] on a rising clk edge when in_wr_enable=1 and reset=0; one-cycle write latency.
REQ-016 x0 SHALL always read 0; writes with in_rd_regno=0 SHALL be discarded.
REQ-017 Write-to-read bypass: when in_wr_enable=1, in_rd_regno!=0 and in_rd_regno equals a read index, that read port SHALL return in_rd_value in the same cycle.
REQ-018 Both read ports addressing the same register SHALL return identical values.
REQ-019 out_a0..out_a7 SHALL reflect stored contents of x10..x17 only (no bypass); they update the cycle after a write.
REQ-020 No handshake; block is always ready; writes every enabled cycle SHALL be accepted back-to-back.
REQ-021 Index arithmetic SHALL be unsigned; all indices 0..31 valid; no wrap or out-of-range case exists.

Reset
REQ-022 On a rising edge with reset=1, all 32 registers SHALL become 0; reset SHALL take priority over a simultaneous write.
REQ-023 After reset, out_rs1_value, out_rs2_value (absent bypass) and out_a0..out_a7 SHALL read 0.
REQ-024 Reset asserted mid-operation SHALL discard any pending write in that cycle; normal writes resume the first edge with reset=0.

Configuration
REQ-025 Macro REGFILE_DISPLAY_EN: when defined, on each rising edge with display_regs=1 the block SHALL print (simulation $display) all 32 registers, one line each, ABI name (zero, ra, sp, gp, tp, t0-t2, s0-s1, a0-a7, s2-s11, t3-t6) and hex value, showing pre-edge contents.
REQ-026 When REGFILE_DISPLAY_EN is undefined, display_regs SHALL be ignored and no print code compiled; register behaviour SHALL be identical in both builds.

Verification
REQ-027 Reset 1 cycle, then read rs1=5, rs2=31 -> both outputs 0; out_a0..out_a7 = 0.
REQ-028 Write x10=0x1234 (wr_enable=1); next cycle read rs1=10 -> 0x1234 and out_a0=0x1234.
REQ-029 Write x0=0xFFFF_FFFF_FFFF_FFFF; next cycle read rs1=0, rs2=0 -> both 0.
REQ-030 Same cycle: wr_enable=1, rd=7, value=0xABCD, rs1=7, rs2=8 -> out_rs1_value=0xABCD, out_rs2_value=old x8; out_a* unchanged that cycle.
REQ-031 Write x17=0x55 while reset=1 -> after edge x17 reads 0 and out_a7=0.
REQ-032 With REGFILE_DISPLAY_EN defined, after writing x2=0x100, pulse display_regs -> 32 lines printed, sp shows 0x100; undefined build -> no output, same register values.
